// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit
// ----------------------------------------------------------------------------
// Program-counter unit for the instruction-fetch stage. It holds the
// registered fetch address and picks the next one from five sources. In
// priority order these are: exception vector, branch/jump redirect,
// return-address-stack top on a return, stall hold, and sequential increment.
// A small circular return-address stack (RAS) predicts the target of a return.
// It is pushed on calls and popped on returns that actually steer the PC.
//
// Parameters:
//   ADDR_W        width of every address
//   INCR          sequential step added to PC_current
//   RESET_VECTOR  PC value after reset
//   EXC_VECTOR    target taken on exc_valid
//   RAS_DEPTH     number of RAS entries (power of two, at least 2)
//
// Ports:
//   clock            rising-edge clock
//   reset_n          synchronous active-low reset
//   stall            hold PC_current; only freezes sequential flow
//   exc_valid        take EXC_VECTOR (highest priority, also blocks a push)
//   redirect_valid   take redirect_target
//   redirect_target  resolved branch/jump address
//   call             push call_link onto the RAS
//   call_link        return address to push
//   ret              return; PC takes the RAS top (pc_plus if RAS empty)
//   PC_current       registered fetch address
//   pc_plus          combinational PC_current + INCR (wraps silently)
//   ras_count        number of valid RAS entries
//   ras_overflow     one-cycle pulse: a push overwrote the oldest entry
//   ras_underflow    one-cycle pulse: a selected ret found the RAS empty
// ============================================================================
module pc_unit #(
    parameter int                ADDR_W       = 10,
    parameter int                INCR         = 1,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(10'h3F0),
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       exc_valid,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_target,
    input  logic                       call,
    input  logic [ADDR_W-1:0]          call_link,
    input  logic                       ret,
    output logic [ADDR_W-1:0]          PC_current,
    output logic [ADDR_W-1:0]          pc_plus,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INCR);

    // Which source feeds the next PC. Naming the choice keeps the priority
    // decode separate from the data mux.
    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_REDIRECT,
        SRC_RAS,
        SRC_HOLD,
        SRC_SEQ
    } pc_src_e;

    pc_src_e            pc_src;
    logic [ADDR_W-1:0]  next_pc;

    // RAS storage. wr_ptr is the next free slot, so the top of stack lives at
    // wr_ptr-1. When the stack is full, wr_ptr points at the oldest entry.
    // A push therefore overwrites the oldest entry without extra logic.
    logic [ADDR_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   top_idx;
    logic [ADDR_W-1:0]  ras_top;
    logic               ras_empty;
    logic               ras_full;

    logic               take_ret;
    logic               do_pop;
    logic               do_push;
    logic               underflow_next;
    logic               overflow_next;
    logic               ras_we;
    logic [PTR_W-1:0]   ras_widx;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [CNT_W-1:0]   count_next;

    // Sequential address. The modulo-2^ADDR_W wrap falls out of the width.
    assign pc_plus = PC_current + STEP;

    assign top_idx   = wr_ptr - PTR_W'(1);
    assign ras_top   = ras_mem[top_idx];
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == FULL_COUNT);

    // Priority decode of the next-PC source. A ret that loses to an exception
    // or redirect is ignored entirely. That includes the stack: it must not
    // pop. A ret on an empty stack falls back to sequential flow and is
    // reported as an underflow.
    always_comb begin
        pc_src   = SRC_SEQ;
        take_ret = 1'b0;
        if (exc_valid) begin
            pc_src = SRC_EXC;
        end else if (redirect_valid) begin
            pc_src = SRC_REDIRECT;
        end else if (ret) begin
            take_ret = 1'b1;
            pc_src   = ras_empty ? SRC_SEQ : SRC_RAS;
        end else if (stall) begin
            pc_src = SRC_HOLD;
        end
    end

    // Data mux for the next PC.
    always_comb begin
        next_pc = pc_plus;
        case (pc_src)
            SRC_EXC:      next_pc = EXC_VECTOR;
            SRC_REDIRECT: next_pc = redirect_target;
            SRC_RAS:      next_pc = ras_top;
            SRC_HOLD:     next_pc = PC_current;
            SRC_SEQ:      next_pc = pc_plus;
            default:      next_pc = pc_plus;
        endcase
    end

    assign do_pop         = take_ret && !ras_empty;
    assign underflow_next = take_ret && ras_empty;
    // A call still pushes under stall or redirect. Only an exception blocks it.
    assign do_push        = call && !exc_valid;

    // Next RAS state.
    // - Push and pop together: the top is consumed by the PC this cycle and
    //   replaced in place by the new link. Depth is unchanged and no flag fires.
    // - Push on a full stack: the write wraps onto the oldest slot. The count
    //   saturates and an overflow pulse is raised.
    // - Push on an empty stack while a ret underflows: this is an ordinary
    //   push, because do_pop is low.
    always_comb begin
        ras_we        = 1'b0;
        ras_widx      = wr_ptr;
        wr_ptr_next   = wr_ptr;
        count_next    = ras_count;
        overflow_next = 1'b0;
        if (do_push && do_pop) begin
            ras_we   = 1'b1;
            ras_widx = top_idx;
        end else if (do_push) begin
            ras_we      = 1'b1;
            ras_widx    = wr_ptr;
            wr_ptr_next = wr_ptr + PTR_W'(1);
            if (ras_full) begin
                overflow_next = 1'b1;
            end else begin
                count_next = ras_count + CNT_W'(1);
            end
        end else if (do_pop) begin
            wr_ptr_next = top_idx;
            count_next  = ras_count - CNT_W'(1);
        end
    end

    // State register. Reset takes precedence over every other input, so a
    // push, pop or redirect pending at a reset edge is discarded. Stack
    // contents are not cleared because ras_count alone defines validity.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            PC_current    <= RESET_VECTOR;
            wr_ptr        <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            PC_current    <= next_pc;
            wr_ptr        <= wr_ptr_next;
            ras_count     <= count_next;
            ras_overflow  <= overflow_next;
            ras_underflow <= underflow_next;
            if (ras_we) begin
                ras_mem[ras_widx] <= call_link;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// ============================================================================
// tb_pc_unit
// ----------------------------------------------------------------------------
// Testbench for pc_unit with default parameters (ADDR_W=10, INCR=1,
// RESET_VECTOR=0, EXC_VECTOR=10'h3F0, RAS_DEPTH=4).
// Each directed vector is driven on a falling edge, and its hand-computed
// post-edge state is queued. The monitor pops one entry shortly after each
// rising edge and compares it with the DUT outputs.
// ============================================================================
module tb_pc_unit;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        exc_valid;
    logic        redirect_valid;
    logic [9:0]  redirect_target;
    logic        call;
    logic [9:0]  call_link;
    logic        ret;
    logic [9:0]  PC_current;
    logic [9:0]  pc_plus;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    typedef struct {
        int         step;
        logic [9:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;
    int   checks  = 0;
    int   fails   = 0;

    pc_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .exc_valid       (exc_valid),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call            (call),
        .call_link       (call_link),
        .ret             (ret),
        .PC_current      (PC_current),
        .pc_plus         (pc_plus),
        .ras_count       (ras_count),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one vector for the coming rising edge, and queue the state
    // expected after that edge.
    task automatic applyStimulus(
        input logic       rst_n_i,
        input logic       st,
        input logic       ex,
        input logic       rd,
        input logic [9:0] tgt,
        input logic       cl,
        input logic [9:0] lnk,
        input logic       rt,
        input logic [9:0] e_pc,
        input logic [2:0] e_cnt,
        input logic       e_ovf,
        input logic       e_unf
    );
        exp_t e;
        @(negedge clock);
        reset_n         = rst_n_i;
        stall           = st;
        exc_valid       = ex;
        redirect_valid  = rd;
        redirect_target = tgt;
        call            = cl;
        call_link       = lnk;
        ret             = rt;
        step_id++;
        e.step = step_id;
        e.pc   = e_pc;
        e.cnt  = e_cnt;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [9:0] e_plus;
        e_plus = e.pc + 10'd1;
        checks++;
        if (PC_current !== e.pc) begin
            fails++;
            $display("[TB] FAIL step %0d PC_current: got %h expected %h", e.step, PC_current, e.pc);
        end
        checks++;
        if (pc_plus !== e_plus) begin
            fails++;
            $display("[TB] FAIL step %0d pc_plus: got %h expected %h", e.step, pc_plus, e_plus);
        end
        checks++;
        if (ras_count !== e.cnt) begin
            fails++;
            $display("[TB] FAIL step %0d ras_count: got %0d expected %0d", e.step, ras_count, e.cnt);
        end
        checks++;
        if (ras_overflow !== e.ovf) begin
            fails++;
            $display("[TB] FAIL step %0d ras_overflow: got %b expected %b", e.step, ras_overflow, e.ovf);
        end
        checks++;
        if (ras_underflow !== e.unf) begin
            fails++;
            $display("[TB] FAIL step %0d ras_underflow: got %b expected %b", e.step, ras_underflow, e.unf);
        end
    endtask

    // Monitor: after every rising edge, compare the DUT with the oldest
    // queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; exc_valid = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; call = 1'b0; call_link = '0; ret = 1'b0;

        $display("[TB] reset and increment");
        //            rst  st  ex  rd  target   cl  link     rt  e_pc     cnt  ovf unf
        applyStimulus(0,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h000, 0,   0,  0);
        applyStimulus(0,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h000, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h001, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h002, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h003, 0,   0,  0);
        applyStimulus(1,   0,  0,  1,  10'h3FF, 0,  10'd0,   0,  10'h3FF, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h000, 0,   0,  0);

        $display("[TB] stall versus redirect");
        applyStimulus(1,   0,  0,  1,  10'h005, 0,  10'd0,   0,  10'h005, 0,   0,  0);
        applyStimulus(1,   1,  0,  0,  10'h000, 0,  10'd0,   0,  10'h005, 0,   0,  0);
        applyStimulus(1,   1,  0,  0,  10'h000, 0,  10'd0,   0,  10'h005, 0,   0,  0);
        applyStimulus(1,   1,  0,  0,  10'h000, 0,  10'd0,   0,  10'h005, 0,   0,  0);
        applyStimulus(1,   1,  0,  1,  10'h080, 0,  10'd0,   0,  10'h080, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h081, 0,   0,  0);

        $display("[TB] RAS call and return");
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd10,  0,  10'h082, 1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd20,  0,  10'h083, 2,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd30,  0,  10'h084, 3,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd30,  2,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd20,  1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd10,  0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd11,  0,   0,  1);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'd12,  0,   0,  0);

        $display("[TB] source priority");
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd7,   0,  10'd13,  1,   0,  0);
        applyStimulus(1,   0,  1,  1,  10'h100, 0,  10'd0,   1,  10'h3F0, 1,   0,  0);
        applyStimulus(1,   0,  0,  1,  10'h200, 0,  10'd0,   1,  10'h200, 1,   0,  0);
        applyStimulus(1,   0,  1,  0,  10'h000, 1,  10'd55,  0,  10'h3F0, 1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd7,   0,   0,  0);

        $display("[TB] RAS overflow");
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd1,   0,  10'd8,   1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd2,   0,  10'd9,   2,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd3,   0,  10'd10,  3,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd4,   0,  10'd11,  4,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd5,   0,  10'd12,  4,   1,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'd13,  4,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd5,   3,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd4,   2,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd3,   1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd2,   0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd3,   0,   0,  1);

        $display("[TB] simultaneous call and return");
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd10,  0,  10'd4,   1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd20,  0,  10'd5,   2,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd99,  1,  10'd20,  2,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd99,  1,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'd10,  0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 1,  10'd44,  1,  10'd11,  1,   0,  1);
        applyStimulus(1,   1,  0,  0,  10'h000, 0,  10'd0,   1,  10'd44,  0,   0,  0);
        applyStimulus(1,   1,  0,  0,  10'h000, 1,  10'd66,  0,  10'd44,  1,   0,  0);

        $display("[TB] reset mid-operation");
        applyStimulus(0,   0,  0,  1,  10'h300, 1,  10'd77,  0,  10'h000, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   0,  10'h001, 0,   0,  0);
        applyStimulus(1,   0,  0,  0,  10'h000, 0,  10'd0,   1,  10'h002, 0,   0,  1);

        @(negedge clock);
        stall = 1'b0; exc_valid = 1'b0; redirect_valid = 1'b0; call = 1'b0; ret = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clock);
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending expectations, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
